// File: rtl/tl_bus_arbiter_if.sv
// TileLink-UL single-beat port bundle (A request channel, D response channel).
// Pure wiring, no latency of its own.
// Both channels use valid/ready; a beat moves only when both are high.
interface tilelink;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic [5:0]  d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;
    logic        d_valid;
    logic        d_ready;

    // Seen from the side that accepts requests and returns responses.
    modport slave (
        input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        output a_ready,
        output d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
        input  d_ready
    );

    // Seen from the side that issues requests and consumes responses.
    modport master (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        input  a_ready,
        input  d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
        output d_ready
    );
endinterface

// File: rtl/tl_bus_arbiter.sv
// Two-requester TileLink-UL arbiter: one transaction in flight, grant held until its D beat fires.
// Latency: one arbitration cycle, then A and D pass through combinationally (3 cycles minimum).
// Backpressure: a_ready/d_ready pass straight through to the granted side; the loser sees a_ready=0.
module tl_bus_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    tilelink.slave    m0,
    tilelink.slave    m1,
    tilelink.master   phy_bus,
    output logic      busy,
    output logic      owner
);

    typedef enum logic [1:0] {IDLE = 2'd0, A_XFER = 2'd1, D_WAIT = 2'd2} state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_grant;
    logic   r_last;
    logic   w_win;
    logic   w_any_req;
    logic   w_gnt_a_valid;
    logic   w_gnt_d_ready;
    logic   w_d_fire;
    logic   w_in_a;
    logic   w_d0;
    logic   w_d1;

    assign w_any_req     = m0.a_valid | m1.a_valid;
    assign w_gnt_a_valid = r_grant ? m1.a_valid : m0.a_valid;
    assign w_gnt_d_ready = r_grant ? m1.d_ready : m0.d_ready;
    assign w_d_fire      = (r_state == D_WAIT) & phy_bus.d_valid & w_gnt_d_ready;
    assign w_in_a        = (r_state == A_XFER);
    assign w_d0          = (r_state == D_WAIT) & ~r_grant;
    assign w_d1          = (r_state == D_WAIT) &  r_grant;

    // Winner selection: a tie goes to m0 in fixed-priority mode, else to whoever did not win last.
    always_comb begin
        w_win = 1'b0;
        if (m0.a_valid && m1.a_valid) begin
            w_win = FIXED_PRIO ? 1'b0 : ~r_last;
        end else begin
            w_win = m1.a_valid;
        end
    end

    // State, grant and last-winner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_any_req) begin
                r_grant <= w_win;
            end
            if (w_d_fire) begin
                r_last <= r_grant;
            end
        end
    end

    // Next state; a requester that drops a_valid before acceptance abandons its grant.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = A_XFER;
            A_XFER: begin
                if (!w_gnt_a_valid) begin
                    w_next_state = IDLE;
                end else if (phy_bus.a_ready) begin
                    w_next_state = D_WAIT;
                end
            end
            D_WAIT:  if (w_d_fire) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs; d_ready stays low in A_XFER so an early D beat waits for D_WAIT.
    always_comb begin
        phy_bus.a_valid = 1'b0;
        phy_bus.d_ready = 1'b0;
        m0.a_ready      = 1'b0;
        m1.a_ready      = 1'b0;
        m0.d_valid      = 1'b0;
        m1.d_valid      = 1'b0;
        case (r_state)
            A_XFER: begin
                phy_bus.a_valid = w_gnt_a_valid;
                m0.a_ready      = ~r_grant & phy_bus.a_ready;
                m1.a_ready      =  r_grant & phy_bus.a_ready;
            end
            D_WAIT: begin
                phy_bus.d_ready = w_gnt_d_ready;
                m0.d_valid      = ~r_grant & phy_bus.d_valid;
                m1.d_valid      =  r_grant & phy_bus.d_valid;
            end
            default: begin
            end
        endcase
    end

    // A-channel payload: granted requester's fields during A_XFER, zero otherwise.
    assign phy_bus.a_opcode  = w_in_a ? (r_grant ? m1.a_opcode  : m0.a_opcode)  : '0;
    assign phy_bus.a_param   = w_in_a ? (r_grant ? m1.a_param   : m0.a_param)   : '0;
    assign phy_bus.a_size    = w_in_a ? (r_grant ? m1.a_size    : m0.a_size)    : '0;
    assign phy_bus.a_source  = w_in_a ? (r_grant ? m1.a_source  : m0.a_source)  : '0;
    assign phy_bus.a_address = w_in_a ? (r_grant ? m1.a_address : m0.a_address) : '0;
    assign phy_bus.a_mask    = w_in_a ? (r_grant ? m1.a_mask    : m0.a_mask)    : '0;
    assign phy_bus.a_data    = w_in_a ? (r_grant ? m1.a_data    : m0.a_data)    : '0;
    assign phy_bus.a_corrupt = w_in_a ? (r_grant ? m1.a_corrupt : m0.a_corrupt) : 1'b0;

    // D-channel payload: routed only to the owner during D_WAIT.
    assign m0.d_opcode  = w_d0 ? phy_bus.d_opcode  : '0;
    assign m0.d_param   = w_d0 ? phy_bus.d_param   : '0;
    assign m0.d_size    = w_d0 ? phy_bus.d_size    : '0;
    assign m0.d_source  = w_d0 ? phy_bus.d_source  : '0;
    assign m0.d_sink    = w_d0 ? phy_bus.d_sink    : '0;
    assign m0.d_denied  = w_d0 ? phy_bus.d_denied  : 1'b0;
    assign m0.d_data    = w_d0 ? phy_bus.d_data    : '0;
    assign m0.d_corrupt = w_d0 ? phy_bus.d_corrupt : 1'b0;
    assign m1.d_opcode  = w_d1 ? phy_bus.d_opcode  : '0;
    assign m1.d_param   = w_d1 ? phy_bus.d_param   : '0;
    assign m1.d_size    = w_d1 ? phy_bus.d_size    : '0;
    assign m1.d_source  = w_d1 ? phy_bus.d_source  : '0;
    assign m1.d_sink    = w_d1 ? phy_bus.d_sink    : '0;
    assign m1.d_denied  = w_d1 ? phy_bus.d_denied  : 1'b0;
    assign m1.d_data    = w_d1 ? phy_bus.d_data    : '0;
    assign m1.d_corrupt = w_d1 ? phy_bus.d_corrupt : 1'b0;

    assign busy  = (r_state != IDLE);
    assign owner = r_grant;

endmodule

// File: tb/tb_tl_bus_arbiter.sv
// Bench for tl_bus_arbiter: round-robin instance driven by a transaction table and
// corner-case sequences with an A/D scoreboard; fixed-priority instance checked separately.
module tb_tl_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tilelink rm0();
    tilelink rm1();
    tilelink rphy();
    tilelink fm0();
    tilelink fm1();
    tilelink fphy();

    logic busy, owner, fbusy, fowner;

    tl_bus_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst), .m0(rm0), .m1(rm1), .phy_bus(rphy), .busy(busy), .owner(owner));
    tl_bus_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst(rst), .m0(fm0), .m1(fm1), .phy_bus(fphy), .busy(fbusy), .owner(fowner));

    typedef struct { logic [3:0] src; logic [63:0] addr; logic [2:0] op; logic [63:0] dat; } a_exp_t;
    typedef struct { bit who; logic [63:0] dat; logic [3:0] src; } d_exp_t;
    typedef struct { bit r0; bit r1; bit own; int aw; int dw; int drw; bit early; } vec_t;

    a_exp_t aq[$];
    d_exp_t dq[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_afire = 0;
    int n_dfire = 0;
    int xn      = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sb_d(input bit who, input logic [63:0] dat, input logic [3:0] src);
        d_exp_t e;
        n_dfire++;
        if (dq.size() == 0) begin
            check("sb_d_unexpected", 1'b1, 1'b0);
        end else begin
            e = dq.pop_front();
            check("sb_d_owner", who, e.who);
            check("sb_d_data", dat, e.dat);
            check("sb_d_source", src, e.src);
        end
    endtask

    // Scoreboard monitor: every A fire at the fabric and every D delivery to a requester.
    always @(negedge clk) begin
        a_exp_t e;
        if (!rst) begin
            if (rphy.a_valid && rphy.a_ready) begin
                n_afire++;
                if (aq.size() == 0) begin
                    check("sb_a_unexpected", 1'b1, 1'b0);
                end else begin
                    e = aq.pop_front();
                    check("sb_a_source", rphy.a_source, e.src);
                    check("sb_a_address", rphy.a_address, e.addr);
                    check("sb_a_opcode", rphy.a_opcode, e.op);
                    check("sb_a_data", rphy.a_data, e.dat);
                end
            end
            if (rm0.d_valid && rm0.d_ready) sb_d(1'b0, rm0.d_data, rm0.d_source);
            if (rm1.d_valid && rm1.d_ready) sb_d(1'b1, rm1.d_data, rm1.d_source);
        end
    end

    task automatic set_reqs(input bit r0, input bit r1);
        rm0.a_valid = r0; rm0.a_opcode = 3'd4; rm0.a_param = 3'd0; rm0.a_size = 3'd3;
        rm0.a_source = 4'h2; rm0.a_address = 64'h8000_0000 + 64'(xn - 1) * 8;
        rm0.a_mask = 8'hFF; rm0.a_data = 64'h0; rm0.a_corrupt = 1'b0;
        rm1.a_valid = r1; rm1.a_opcode = 3'd0; rm1.a_param = 3'd0; rm1.a_size = 3'd3;
        rm1.a_source = 4'h9; rm1.a_address = 64'h1000_0000 + 64'(xn - 1) * 8;
        rm1.a_mask = 8'h0F; rm1.a_data = 64'hCAFE_0000_0000_0000 | 64'(xn); rm1.a_corrupt = 1'b0;
    endtask

    task automatic drive_d(input logic [63:0] dat, input logic [3:0] src);
        rphy.d_valid = 1'b1; rphy.d_opcode = 3'd1; rphy.d_param = 2'd0; rphy.d_size = 3'd3;
        rphy.d_source = src; rphy.d_sink = 6'h5; rphy.d_denied = 1'b0; rphy.d_data = dat;
        rphy.d_corrupt = 1'b0;
    endtask

    // One complete transaction on the round-robin instance, starting and ending in IDLE.
    task automatic rr_xact(input bit r0, input bit r1, input bit own, input int aw,
                           input int dw, input int drw, input bit early);
        logic [63:0] rdat;
        logic [3:0]  src;
        int fa, fd;
        bit done, exp_dv, exp_dr;
        xn++;
        set_reqs(r0, r1);
        src  = own ? 4'h9 : 4'h2;
        rdat = 64'hDEAD_BEEF_0000_0000 | 64'(xn);
        aq.push_back('{src, own ? rm1.a_address : rm0.a_address,
                       own ? rm1.a_opcode : rm0.a_opcode, own ? rm1.a_data : rm0.a_data});
        dq.push_back('{own, rdat, src});
        fa = n_afire;
        fd = n_dfire;
        @(negedge clk);
        check("arb_cycle_busy", busy, 1'b0);
        check("arb_cycle_a_valid", rphy.a_valid, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i <= aw; i++) begin
            rphy.a_ready = (i == aw);
            if (i == aw && early) drive_d(rdat, src);
            @(negedge clk);
            check("a_phase_a_valid", rphy.a_valid, 1'b1);
            check("a_phase_busy", busy, 1'b1);
            check("a_phase_owner", owner, own);
            check("a_phase_addr_stable", rphy.a_address, aq[0].addr);
            check("a_phase_win_a_ready", own ? rm1.a_ready : rm0.a_ready, (i == aw));
            check("a_phase_lose_a_ready", own ? rm0.a_ready : rm1.a_ready, 1'b0);
            check("a_phase_d_ready", rphy.d_ready, 1'b0);
            check("a_phase_win_d_valid", own ? rm1.d_valid : rm0.d_valid, 1'b0);
            @(posedge clk); #1;
        end
        rphy.a_ready = 1'b0;
        if (own) rm1.a_valid = 1'b0; else rm0.a_valid = 1'b0;
        done = 1'b0;
        for (int j = 0; j < 20 && !done; j++) begin
            exp_dv = early || (j >= dw);
            exp_dr = (j >= dw + drw);
            if (exp_dv) drive_d(rdat, src);
            if (own) rm1.d_ready = exp_dr; else rm0.d_ready = exp_dr;
            @(negedge clk);
            check("d_phase_a_valid", rphy.a_valid, 1'b0);
            check("d_phase_busy", busy, 1'b1);
            check("d_phase_owner", owner, own);
            check("d_phase_win_d_valid", own ? rm1.d_valid : rm0.d_valid, exp_dv);
            check("d_phase_lose_d_valid", own ? rm0.d_valid : rm1.d_valid, 1'b0);
            check("d_phase_lose_a_ready", own ? rm0.a_ready : rm1.a_ready, 1'b0);
            check("d_phase_d_ready", rphy.d_ready, exp_dr);
            done = rphy.d_valid && rphy.d_ready;
            @(posedge clk); #1;
        end
        check("d_fire_seen", done, 1'b1);
        rphy.d_valid = 1'b0;
        rm0.d_ready = 1'b0; rm1.d_ready = 1'b0;
        rm0.a_valid = 1'b0; rm1.a_valid = 1'b0;
        @(negedge clk);
        check("post_busy", busy, 1'b0);
        check("a_fire_count", n_afire - fa, 1);
        check("d_fire_count", n_dfire - fd, 1);
        @(posedge clk); #1;
    endtask

    task automatic clear_all();
        set_reqs(1'b0, 1'b0);
        rm0.d_ready = 1'b0; rm1.d_ready = 1'b0;
        rphy.a_ready = 1'b0;
        drive_d(64'h0, 4'h0);
        rphy.d_valid = 1'b0;
        fm0.a_valid = 1'b0; fm0.a_opcode = 3'd4; fm0.a_param = 3'd0; fm0.a_size = 3'd3;
        fm0.a_source = 4'h2; fm0.a_address = 64'h8000_0000; fm0.a_mask = 8'hFF;
        fm0.a_data = 64'h0; fm0.a_corrupt = 1'b0; fm0.d_ready = 1'b0;
        fm1.a_valid = 1'b0; fm1.a_opcode = 3'd4; fm1.a_param = 3'd0; fm1.a_size = 3'd3;
        fm1.a_source = 4'h9; fm1.a_address = 64'h1000_0000; fm1.a_mask = 8'hFF;
        fm1.a_data = 64'h0; fm1.a_corrupt = 1'b0; fm1.d_ready = 1'b0;
        fphy.a_ready = 1'b0; fphy.d_valid = 1'b0; fphy.d_opcode = 3'd1; fphy.d_param = 2'd0;
        fphy.d_size = 3'd3; fphy.d_source = 4'h0; fphy.d_sink = 6'h0; fphy.d_denied = 1'b0;
        fphy.d_data = 64'h1234; fphy.d_corrupt = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    vec_t tbl[8];
    int   fcnt;
    bit   fgot1;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 5, 0, 3, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 0, 2, 0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1, 0, 1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 2, 0, 0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0};

        // Reset state with the surrounding handshakes pulled high.
        clear_all();
        rm0.a_valid = 1'b1; rm1.a_valid = 1'b1; rm0.d_ready = 1'b1; rm1.d_ready = 1'b1;
        rphy.a_ready = 1'b1; rphy.d_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 1'b0);
        check("rst_phy_a_valid", rphy.a_valid, 1'b0);
        check("rst_phy_d_ready", rphy.d_ready, 1'b0);
        check("rst_m0_a_ready", rm0.a_ready, 1'b0);
        check("rst_m1_a_ready", rm1.a_ready, 1'b0);
        check("rst_m0_d_valid", rm0.d_valid, 1'b0);
        check("rst_m1_d_valid", rm1.d_valid, 1'b0);
        check("rst_phy_a_address", rphy.a_address, 64'h0);
        check("rst_fp_busy", fbusy, 1'b0);
        do_reset();

        // Single m0 Get, zero-wait slave.
        rr_xact(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        // From reset, both requesting continuously: strict alternation starting at m0.
        do_reset();
        for (int i = 0; i < 8; i++) rr_xact(1'b1, 1'b1, i[0], 0, 0, 0, 1'b0);

        // Mixed patterns, backpressure and early-D vectors.
        for (int i = 0; i < 8; i++)
            rr_xact(tbl[i].r0, tbl[i].r1, tbl[i].own, tbl[i].aw, tbl[i].dw, tbl[i].drw, tbl[i].early);

        // Reset while m1 owns the bus with a D beat pending.
        xn++;
        set_reqs(1'b0, 1'b1);
        rphy.a_ready = 1'b1;
        aq.push_back('{4'h9, rm1.a_address, rm1.a_opcode, rm1.a_data});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rm1.a_valid = 1'b0;
        rphy.a_ready = 1'b0;
        drive_d(64'h5555, 4'h9);
        rm1.d_ready = 1'b0;
        @(negedge clk);
        check("mid_owner", owner, 1'b1);
        check("mid_busy", busy, 1'b1);
        check("mid_m1_d_valid", rm1.d_valid, 1'b1);
        #2;
        rst = 1'b1;
        rm1.d_ready = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_m1_d_valid", rm1.d_valid, 1'b0);
        check("mid_rst_phy_d_ready", rphy.d_ready, 1'b0);
        check("mid_rst_owner", owner, 1'b0);
        @(posedge clk); #1;
        rphy.d_valid = 1'b0;
        rm1.d_ready = 1'b0;
        rst = 1'b0;
        rr_xact(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);

        // Fixed priority: m0 keeps winning while it requests, then m1 is served.
        fm0.a_valid = 1'b1; fm1.a_valid = 1'b1;
        fm0.d_ready = 1'b1; fm1.d_ready = 1'b1;
        fphy.a_ready = 1'b1; fphy.d_valid = 1'b1;
        fcnt = 0;
        fgot1 = 1'b0;
        for (int c = 0; c < 40 && !fgot1; c++) begin
            @(negedge clk);
            if (fphy.a_valid && fphy.a_ready) begin
                if (fcnt < 3) begin
                    check("fp_owner_m0", fowner, 1'b0);
                    check("fp_src_m0", fphy.a_source, 4'h2);
                    check("fp_m1_a_ready", fm1.a_ready, 1'b0);
                    fcnt++;
                end else begin
                    check("fp_owner_m1", fowner, 1'b1);
                    check("fp_src_m1", fphy.a_source, 4'h9);
                    fgot1 = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (fcnt == 3) fm0.a_valid = 1'b0;
        end
        check("fp_m0_count", fcnt, 3);
        check("fp_m1_served", fgot1, 1'b1);
        fm1.a_valid = 1'b0;
        repeat (4) @(posedge clk);

        check("sb_a_drained", 64'(aq.size()), 64'd0);
        check("sb_d_drained", 64'(dq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
